// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit with region decode, byte lanes, sync-read memory
//            sequencing, MMIO wait states and sign/zero-extended load return.
//            Optional macro MISALIGN_SPLIT_EN enables two-beat word-crossing
//            accesses; when undefined such accesses fault.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int BIOS_AW = 12,
    parameter int DMEM_AW = 14,
    parameter int IMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic               pc30,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [BIOS_AW-1:0] bios_addrb,
    input  logic [31:0]        bios_doutb,
    output logic [DMEM_AW-1:0] dmem_addra,
    output logic [31:0]        dmem_dina,
    output logic [3:0]         dmem_wea,
    input  logic [31:0]        dmem_douta,
    output logic [IMEM_AW-1:0] imem_addra,
    output logic [31:0]        imem_dina,
    output logic [3:0]         imem_wea,
    output logic               mmio_valid,
    input  logic               mmio_ready,
    output logic [31:0]        mmio_addr,
    output logic               mmio_we,
    output logic [31:0]        mmio_wdata,
    output logic [3:0]         mmio_wstrb,
    input  logic [31:0]        mmio_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_BEAT1 = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_MMIO  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic        r_we;
    logic        r_bios;
    logic        r_dmem;
    logic        r_imem;
    logic        r_split;
    logic        r_err;
    logic [31:0] r_rd0;
    logic [31:0] r_resp_rdata;

    // ------------------------------------------------------------------
    // Request decode (combinational on the incoming request)
    // ------------------------------------------------------------------
    logic       w_f3_ok;
    logic       w_misal;
    logic [7:0] w_strb8;
    logic       w_cross;
    logic       w_is_bios;
    logic       w_is_mmio;
    logic       w_dmem_hit;
    logic       w_imem_hit;
    logic       w_no_target;
    logic       w_split;
    logic       w_cross_err;
    logic       w_fault;

    always_comb begin
        w_f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !req_we;
            default:                w_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_misal = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = |req_addr[1:0];
            default: w_misal = 1'b0;
        endcase
    end

    assign w_strb8     = {4'b0000, size_mask(req_funct3[1:0])} << req_addr[1:0];
    assign w_cross     = |w_strb8[7:4];
    assign w_is_bios   = (req_addr[31:28] == 4'b0100);
    assign w_is_mmio   = (req_addr[31:28] == 4'b1000);
    assign w_dmem_hit  = !w_is_bios && !w_is_mmio && req_addr[28];
    assign w_imem_hit  = !w_is_bios && !w_is_mmio && req_we && req_addr[29] && pc30;
    assign w_no_target = !w_is_bios && !w_is_mmio &&
                         (req_we ? !(w_dmem_hit || w_imem_hit) : !w_dmem_hit);

`ifdef MISALIGN_SPLIT_EN
    assign w_split     = w_cross && !w_is_mmio;
    assign w_cross_err = 1'b0;
`else
    assign w_split     = 1'b0;
    assign w_cross_err = w_cross;
`endif

    assign w_fault = !w_f3_ok || w_no_target || (w_is_bios && req_we) ||
                     (w_is_mmio && w_misal) || w_cross_err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault)        w_next = S_ERR;
                    else if (w_is_mmio) w_next = S_MMIO;
                    else                w_next = S_BEAT0;
                end
            end
            S_BEAT0: w_next = S_WAIT0;
            S_WAIT0: w_next = r_split ? S_BEAT1 : S_RESP;
            S_BEAT1: w_next = S_WAIT1;
            S_WAIT1: w_next = S_RESP;
            S_MMIO:  w_next = mmio_ready ? S_RESP : S_MMIO;
            S_ERR:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and load-data datapath
    // ------------------------------------------------------------------
    logic [7:0]  w_r_strb8;
    logic [63:0] w_wd64;
    logic [31:0] w_rd_word;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic [31:0] w_sh32;
    logic [31:0] w_ext;
    logic        w_cap;
    logic        w_hi_sel;

    assign w_r_strb8 = {4'b0000, size_mask(r_f3[1:0])} << r_addr[1:0];
    assign w_wd64    = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_rd_word = r_bios ? bios_doutb : dmem_douta;
    assign w_hi_sel  = (r_state == S_BEAT1) || (r_state == S_WAIT1);

    always_comb begin
        w_lo = w_rd_word;
        w_hi = w_rd_word;
        case (r_state)
            S_WAIT1: begin
                w_lo = r_rd0;
                w_hi = w_rd_word;
            end
            S_MMIO: begin
                w_lo = mmio_rdata;
                w_hi = 32'h0;
            end
            default: begin
                w_lo = w_rd_word;
                w_hi = w_rd_word;
            end
        endcase
    end

    assign w_sh32 = 32'({w_hi, w_lo} >> {r_addr[1:0], 3'b000});

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_sh32[7]}}, w_sh32[7:0]};
            3'b001:  w_ext = {{16{w_sh32[15]}}, w_sh32[15:0]};
            3'b100:  w_ext = {24'h0, w_sh32[7:0]};
            3'b101:  w_ext = {16'h0, w_sh32[15:0]};
            default: w_ext = w_sh32;
        endcase
    end

    // Load data is captured on the edge that completes the last data beat
    assign w_cap = !r_we && (((r_state == S_WAIT0) && !r_split) ||
                             (r_state == S_WAIT1) ||
                             ((r_state == S_MMIO) && mmio_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_f3         <= 3'b000;
            r_we         <= 1'b0;
            r_bios       <= 1'b0;
            r_dmem       <= 1'b0;
            r_imem       <= 1'b0;
            r_split      <= 1'b0;
            r_err        <= 1'b0;
            r_rd0        <= 32'h0;
            r_resp_rdata <= 32'h0;
        end else begin
            if ((r_state == S_IDLE) && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_f3    <= req_funct3;
                r_we    <= req_we;
                r_bios  <= w_is_bios;
                r_dmem  <= w_dmem_hit;
                r_imem  <= w_imem_hit;
                r_split <= w_split;
                r_err   <= w_fault;
            end
            if (r_state == S_WAIT0) begin
                r_rd0 <= w_rd_word;
            end
            if (w_cap) begin
                r_resp_rdata <= w_ext;
            end else if (r_state == S_RESP) begin
                r_resp_rdata <= 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    logic       w_beat;
    logic [3:0] w_beat_strb;

    always_comb begin
        w_beat      = (r_state == S_BEAT0) || (r_state == S_BEAT1);
        w_beat_strb = (r_state == S_BEAT1) ? w_r_strb8[7:4] : w_r_strb8[3:0];

        req_ready   = (r_state == S_IDLE);
        resp_valid  = (r_state == S_RESP);
        resp_err    = (r_state == S_RESP) && r_err;
        resp_rdata  = r_resp_rdata;

        bios_addrb  = r_addr[BIOS_AW+1:2] + {{(BIOS_AW-1){1'b0}}, w_hi_sel};
        dmem_addra  = r_addr[DMEM_AW+1:2] + {{(DMEM_AW-1){1'b0}}, w_hi_sel};
        imem_addra  = r_addr[IMEM_AW+1:2] + {{(IMEM_AW-1){1'b0}}, w_hi_sel};
        dmem_dina   = (r_state == S_BEAT1) ? w_wd64[63:32] : w_wd64[31:0];
        imem_dina   = dmem_dina;
        dmem_wea    = (w_beat && r_we && r_dmem) ? w_beat_strb : 4'b0000;
        imem_wea    = (w_beat && r_we && r_imem) ? w_beat_strb : 4'b0000;

        mmio_valid  = (r_state == S_MMIO);
        mmio_addr   = mmio_valid ? r_addr : 32'h0;
        mmio_we     = mmio_valid && r_we;
        mmio_wdata  = mmio_we ? w_wd64[31:0] : 32'h0;
        mmio_wstrb  = mmio_we ? w_r_strb8[3:0] : 4'b0000;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int NCAP = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic        pc30;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] bios_addrb;
    logic [31:0] bios_doutb;
    logic [13:0] dmem_addra;
    logic [31:0] dmem_dina;
    logic [3:0]  dmem_wea;
    logic [31:0] dmem_douta;
    logic [13:0] imem_addra;
    logic [31:0] imem_dina;
    logic [3:0]  imem_wea;
    logic        mmio_valid;
    logic        mmio_ready;
    logic [31:0] mmio_addr;
    logic        mmio_we;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic [31:0] mmio_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.BIOS_AW(12), .DMEM_AW(14), .IMEM_AW(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3), .pc30(pc30),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bios_addrb(bios_addrb), .bios_doutb(bios_doutb),
        .dmem_addra(dmem_addra), .dmem_dina(dmem_dina), .dmem_wea(dmem_wea), .dmem_douta(dmem_douta),
        .imem_addra(imem_addra), .imem_dina(imem_dina), .imem_wea(imem_wea),
        .mmio_valid(mmio_valid), .mmio_ready(mmio_ready), .mmio_addr(mmio_addr),
        .mmio_we(mmio_we), .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata)
    );

    // Synchronous-read memory models and a programmable-latency MMIO target
    logic [31:0] dmem_m [0:16383];
    logic [31:0] bios_m [0:4095];
    int          mmio_delay = 0;
    int          mmio_cnt = 0;

    initial begin
        for (int i = 0; i < 4096; i++) bios_m[i] = 32'h0;
        bios_m[0] = 32'h0080_0000;
    end

    always @(posedge clk) begin
        dmem_douta <= dmem_m[dmem_addra];
        bios_doutb <= bios_m[bios_addrb];
        for (int i = 0; i < 4; i++)
            if (dmem_wea[i]) dmem_m[dmem_addra][8*i +: 8] <= dmem_dina[8*i +: 8];
        if (mmio_valid && !mmio_ready) mmio_cnt <= mmio_cnt + 1;
        else                           mmio_cnt <= 0;
    end

    assign mmio_ready = mmio_valid && (mmio_cnt == mmio_delay);

    // Per-cycle observations after acceptance (index 1 = first cycle after)
    logic [3:0]  l_dwea  [0:NCAP];
    logic [13:0] l_daddr [0:NCAP];
    logic [31:0] l_ddina [0:NCAP];
    logic [3:0]  l_iwea  [0:NCAP];
    logic [13:0] l_iaddr [0:NCAP];
    logic [31:0] l_idina [0:NCAP];
    logic [11:0] l_baddr [0:NCAP];
    logic        l_mv    [0:NCAP];
    logic [31:0] l_maddr [0:NCAP];
    logic [31:0] l_mwd   [0:NCAP];
    logic [3:0]  l_mstrb [0:NCAP];
    logic        l_mwe   [0:NCAP];
    int          resp_k, n_resp, n_dwea, n_iwea, n_mv;
    logic [31:0] r_rdata;
    logic        r_err;

    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic [2:0] f3, input logic p30);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_we = we; req_funct3 = f3; pc30 = p30;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        resp_k = 0; n_resp = 0; n_dwea = 0; n_iwea = 0; n_mv = 0;
        r_rdata = 32'hXXXX_XXXX; r_err = 1'bx;
        for (int k = 1; k <= NCAP; k++) begin
            l_dwea[k] = dmem_wea; l_daddr[k] = dmem_addra; l_ddina[k] = dmem_dina;
            l_iwea[k] = imem_wea; l_iaddr[k] = imem_addra; l_idina[k] = imem_dina;
            l_baddr[k] = bios_addrb; l_mv[k] = mmio_valid; l_maddr[k] = mmio_addr;
            l_mwd[k] = mmio_wdata; l_mstrb[k] = mmio_wstrb; l_mwe[k] = mmio_we;
            if (dmem_wea != 4'b0) n_dwea++;
            if (imem_wea != 4'b0) n_iwea++;
            if (mmio_valid) n_mv++;
            if (resp_valid) begin
                n_resp++;
                if (resp_k == 0) begin
                    resp_k = k; r_rdata = resp_rdata; r_err = resp_err;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_we = 1'b0; req_funct3 = 3'b000; pc30 = 1'b0; mmio_rdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        checks++; if ({resp_valid, resp_err} !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        checks++; if ({dmem_wea, imem_wea, mmio_wstrb} !== 12'h0) begin errors++; $display("FAIL rst_en got %h exp 000", {dmem_wea, imem_wea, mmio_wstrb}); end
        checks++; if ({mmio_valid, mmio_we} !== 2'b00) begin errors++; $display("FAIL rst_mmio got %b exp 00", {mmio_valid, mmio_we}); end
        checks++; if ({dmem_addra, imem_addra, bios_addrb} !== 40'h0 || mmio_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h/%h exp 0", {dmem_addra, imem_addra, bios_addrb}, mmio_addr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_dmem();
        run_req(32'h1000_0008, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0);
        checks++; if (l_daddr[1] !== 14'd2) begin errors++; $display("FAIL sw_addr got %0d exp 2", l_daddr[1]); end
        checks++; if (l_dwea[1] !== 4'b1111) begin errors++; $display("FAIL sw_wea got %b exp 1111", l_dwea[1]); end
        checks++; if (l_ddina[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_dina got %h exp deadbeef", l_ddina[1]); end
        checks++; if (n_dwea !== 1) begin errors++; $display("FAIL sw_wea_cycles got %0d exp 1", n_dwea); end
        checks++; if (n_iwea !== 0) begin errors++; $display("FAIL sw_imem got %0d exp 0", n_iwea); end
        checks++; if (resp_k !== 3 || n_resp !== 1) begin errors++; $display("FAIL sw_lat got %0d/%0d exp 3/1", resp_k, n_resp); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin errors++; $display("FAIL sw_resp got %b/%h exp 0/0", r_err, r_rdata); end
    endtask

    task automatic test_store_dual();
        run_req(32'h3000_0005, 32'h0000_00AB, 1'b1, 3'b000, 1'b1);
        checks++; if (l_dwea[1] !== 4'b0010 || l_iwea[1] !== 4'b0010) begin errors++; $display("FAIL sb_wea got %b/%b exp 0010/0010", l_dwea[1], l_iwea[1]); end
        checks++; if (l_ddina[1][15:8] !== 8'hAB || l_idina[1][15:8] !== 8'hAB) begin errors++; $display("FAIL sb_lane got %h/%h exp ab", l_ddina[1][15:8], l_idina[1][15:8]); end
        checks++; if (l_daddr[1] !== 14'd1 || l_iaddr[1] !== 14'd1) begin errors++; $display("FAIL sb_addr got %0d/%0d exp 1/1", l_daddr[1], l_iaddr[1]); end
        checks++; if (resp_k !== 3 || r_err !== 1'b0) begin errors++; $display("FAIL sb_resp got %0d/%b exp 3/0", resp_k, r_err); end
        run_req(32'h3000_0005, 32'h0000_00AB, 1'b1, 3'b000, 1'b0);
        checks++; if (l_dwea[1] !== 4'b0010 || n_iwea !== 0) begin errors++; $display("FAIL sb_nopc got %b/%0d exp 0010/0", l_dwea[1], n_iwea); end
    endtask

    task automatic test_load_ext();
        run_req(32'h1000_000A, 32'h0, 1'b0, 3'b001, 1'b0);
        checks++; if (resp_k !== 3 || r_rdata !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh got %0d/%h exp 3/ffffdead", resp_k, r_rdata); end
        run_req(32'h1000_000A, 32'h0, 1'b0, 3'b101, 1'b0);
        checks++; if (r_rdata !== 32'h0000_DEAD) begin errors++; $display("FAIL lhu got %h exp 0000dead", r_rdata); end
        run_req(32'h1000_0008, 32'h0, 1'b0, 3'b010, 1'b0);
        checks++; if (r_rdata !== 32'hDEAD_BEEF || n_dwea !== 0) begin errors++; $display("FAIL lw got %h/%0d exp deadbeef/0", r_rdata, n_dwea); end
        run_req(32'h4000_0002, 32'h0, 1'b0, 3'b000, 1'b0);
        checks++; if (l_baddr[1] !== 12'd0) begin errors++; $display("FAIL lb_addr got %0d exp 0", l_baddr[1]); end
        checks++; if (resp_k !== 3 || r_rdata !== 32'hFFFF_FF80 || r_err !== 1'b0) begin errors++; $display("FAIL lb got %0d/%h/%b exp 3/ffffff80/0", resp_k, r_rdata, r_err); end
        run_req(32'h4000_0002, 32'h0, 1'b0, 3'b100, 1'b0);
        checks++; if (r_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", r_rdata); end
    endtask

    task automatic test_misalign();
        run_req(32'h1000_0000, 32'h4433_2211, 1'b1, 3'b010, 1'b0);
        run_req(32'h1000_0004, 32'h8877_6655, 1'b1, 3'b010, 1'b0);
        run_req(32'h1000_0003, 32'h0, 1'b0, 3'b010, 1'b0);
`ifdef MISALIGN_SPLIT_EN
        checks++; if (l_daddr[1] !== 14'd0 || l_daddr[3] !== 14'd1) begin errors++; $display("FAIL split_addr got %0d/%0d exp 0/1", l_daddr[1], l_daddr[3]); end
        checks++; if (resp_k !== 5 || r_err !== 1'b0 || r_rdata !== 32'h7766_5544) begin errors++; $display("FAIL split_lw got %0d/%b/%h exp 5/0/77665544", resp_k, r_err, r_rdata); end
        run_req(32'h1000_0002, 32'hAABB_CCDD, 1'b1, 3'b010, 1'b0);
        checks++; if (l_dwea[1] !== 4'b1100 || l_dwea[3] !== 4'b0011 || l_ddina[3][15:0] !== 16'hAABB) begin errors++; $display("FAIL split_sw got %b/%b/%h exp 1100/0011/aabb", l_dwea[1], l_dwea[3], l_ddina[3][15:0]); end
`else
        checks++; if (resp_k !== 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL mis_lw got %0d/%b/%h exp 2/1/0", resp_k, r_err, r_rdata); end
        run_req(32'h1000_0002, 32'hAABB_CCDD, 1'b1, 3'b010, 1'b0);
        checks++; if (resp_k !== 2 || r_err !== 1'b1 || n_dwea !== 0) begin errors++; $display("FAIL mis_sw got %0d/%b/%0d exp 2/1/0", resp_k, r_err, n_dwea); end
`endif
        run_req(32'h1000_0001, 32'h0, 1'b0, 3'b101, 1'b0);
        checks++; if (resp_k !== 3 || r_rdata !== 32'h0000_3322) begin errors++; $display("FAIL lhu_off1 got %0d/%h exp 3/00003322", resp_k, r_rdata); end
    endtask

    task automatic test_mmio();
        mmio_delay = 4;
        run_req(32'h8000_0010, 32'h1234_5678, 1'b1, 3'b010, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (l_mv[k] !== 1'b1 || l_maddr[k] !== 32'h8000_0010 || l_mwd[k] !== 32'h1234_5678 ||
                l_mstrb[k] !== 4'b1111 || l_mwe[k] !== 1'b1)
            begin errors++; $display("FAIL mmio_hold[%0d] got %b/%h/%h/%b exp 1/80000010/12345678/1111", k, l_mv[k], l_maddr[k], l_mwd[k], l_mstrb[k]); end
        end
        checks++; if (n_mv !== 5) begin errors++; $display("FAIL mmio_cycles got %0d exp 5", n_mv); end
        checks++; if (resp_k !== 6 || n_resp !== 1 || r_err !== 1'b0) begin errors++; $display("FAIL mmio_resp got %0d/%0d/%b exp 6/1/0", resp_k, n_resp, r_err); end
        mmio_delay = 0;
        run_req(32'h8000_0020, 32'h0, 1'b0, 3'b010, 1'b0);
        checks++; if (resp_k !== 2 || r_rdata !== 32'hCAFE_F00D || l_mwe[1] !== 1'b0) begin errors++; $display("FAIL mmio_lw got %0d/%h/%b exp 2/cafef00d/0", resp_k, r_rdata, l_mwe[1]); end
        run_req(32'h8000_0001, 32'h0, 1'b0, 3'b001, 1'b0);
        checks++; if (resp_k !== 2 || r_err !== 1'b1 || n_mv !== 0) begin errors++; $display("FAIL mmio_mis got %0d/%b/%0d exp 2/1/0", resp_k, r_err, n_mv); end
    endtask

    task automatic test_errors();
        run_req(32'h4000_0000, 32'h1111_1111, 1'b1, 3'b010, 1'b1);
        checks++; if (resp_k !== 2 || r_err !== 1'b1 || n_dwea !== 0 || n_iwea !== 0) begin errors++; $display("FAIL bios_sw got %0d/%b/%0d/%0d exp 2/1/0/0", resp_k, r_err, n_dwea, n_iwea); end
        run_req(32'h1000_0000, 32'h0, 1'b0, 3'b011, 1'b0);
        checks++; if (resp_k !== 2 || r_err !== 1'b1) begin errors++; $display("FAIL bad_f3 got %0d/%b exp 2/1", resp_k, r_err); end
        run_req(32'h1000_0000, 32'h0, 1'b1, 3'b100, 1'b0);
        checks++; if (r_err !== 1'b1 || n_dwea !== 0) begin errors++; $display("FAIL bad_sf3 got %b/%0d exp 1/0", r_err, n_dwea); end
        run_req(32'h0000_0000, 32'h0, 1'b0, 3'b010, 1'b0);
        checks++; if (resp_k !== 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL no_region got %0d/%b/%h exp 2/1/0", resp_k, r_err, r_rdata); end
        run_req(32'h2000_0000, 32'h0, 1'b1, 3'b010, 1'b0);
        checks++; if (r_err !== 1'b1 || n_iwea !== 0) begin errors++; $display("FAIL imem_nopc got %b/%0d exp 1/0", r_err, n_iwea); end
    endtask

    task automatic test_reset_midop();
        bit seen;
        run_req(32'h1000_0010, 32'h0000_0000, 1'b1, 3'b010, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1000_0010; req_wdata = 32'h1111_1111;
        req_we = 1'b1; req_funct3 = 3'b010; pc30 = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (dmem_wea !== 4'b1111) begin errors++; $display("FAIL abort_pre got %b exp 1111", dmem_wea); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_wea !== 4'b0000) begin errors++; $display("FAIL abort_wea got %b exp 0000", dmem_wea); end
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp got %b exp 0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready); end
        run_req(32'h1000_0010, 32'h0, 1'b0, 3'b010, 1'b0);
        checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL abort_mem got %h exp 0", r_rdata); end
    endtask

    task automatic test_back_to_back();
        run_req(32'h1000_0020, 32'hA5A5_5A5A, 1'b1, 3'b001, 1'b0);
        run_req(32'h1000_0020, 32'h0, 1'b0, 3'b010, 1'b0);
        checks++; if (resp_k !== 3 || r_rdata[15:0] !== 16'h5A5A) begin errors++; $display("FAIL b2b got %0d/%h exp 3/5a5a", resp_k, r_rdata[15:0]); end
    endtask

    initial begin
        test_reset();
        test_store_dmem();
        test_store_dual();
        test_load_ext();
        test_misalign();
        test_mmio();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
